frame_draw_sequencer: RTL

FRAME_DRAW_SEQUENCER -- requirements
Module: frame_draw_sequencer

---
 rtl/veggie_pkg.sv | 25 ++
 rtl/cmd_fifo.sv | 46 ++++
 rtl/frame_draw_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/veggie_pkg.sv
// Shared constants and types for the frame draw sequencer: default raster size,
// frame buffer address width, FSM state encoding and the rectangle command record.
package veggie_pkg;

    localparam int unsigned H_RES     = 640;
    localparam int unsigned V_RES     = 480;
    localparam int unsigned FB_ADDR_W = 19;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StDraw,
        StDone
    } state_e;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] w;
        logic [9:0] h;
        logic [7:0] color;
    } rect_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead rectangle command FIFO: the head entry is visible on pop_data_o
// whenever empty_o is low. Depth must be a power of two.
module cmd_fifo
    import veggie_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      push_i,
    input  rect_cmd_t push_data_i,
    input  logic      pop_i,
    output rect_cmd_t pop_data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PtrW:0] wr_ptr_q, rd_ptr_q;
    rect_cmd_t     mem_q [Depth];
    logic          push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/frame_draw_sequencer.sv
// Clears the frame buffer to a background colour, then rasterises queued
// rectangles (clipped to the screen) in FIFO order through a registered write port.
module frame_draw_sequencer #(
    parameter int unsigned H_RES      = veggie_pkg::H_RES,
    parameter int unsigned V_RES      = veggie_pkg::V_RES,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [7:0]  bg_color,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [7:0]  cmd_color,
    output logic [18:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        done
);

    import veggie_pkg::*;

    localparam logic [10:0]          HLim     = 11'(H_RES);
    localparam logic [10:0]          VLim     = 11'(V_RES);
    localparam logic [9:0]           HLast    = 10'(H_RES - 1);
    localparam logic [9:0]           VLast    = 10'(V_RES - 1);
    localparam logic [FB_ADDR_W-1:0] LastAddr = FB_ADDR_W'(H_RES * V_RES - 1);

    state_e               state_q;
    logic [FB_ADDR_W-1:0] clr_addr_q, wr_addr_q;
    logic [9:0]           cur_x_q, cur_y_q, x_first_q, x_last_q, y_last_q;
    logic [7:0]           wr_data_q;
    logic                 wr_en_q, done_q;

    rect_cmd_t cmd_in, head;
    logic      fifo_full, fifo_empty, fifo_pop;

    assign cmd_in   = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
    assign fifo_pop = (state_q == StFetch) && !fifo_empty;

    cmd_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i       (Clk),
        .reset_i     (Reset),
        .push_i      (cmd_valid),
        .push_data_i (cmd_in),
        .pop_i       (fifo_pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
        logic [FB_ADDR_W-1:0] xw, yw;
        xw = FB_ADDR_W'(x);
        yw = FB_ADDR_W'(y);
        if (H_RES == 640) return (yw << 9) + (yw << 7) + xw;
        return yw * FB_ADDR_W'(H_RES) + xw;
    endfunction

    // 11-bit sums keep x+w / y+h from wrapping before the clip compare.
    logic [10:0] x_sum, y_sum;
    logic [9:0]  x_last, y_last, nxt_x, nxt_y;
    logic        cmd_drop, last_pix;

    always_comb begin
        x_sum    = {1'b0, head.x} + {1'b0, head.w};
        y_sum    = {1'b0, head.y} + {1'b0, head.h};
        x_last   = (x_sum > HLim) ? HLast : x_sum[9:0] - 10'd1;
        y_last   = (y_sum > VLim) ? VLast : y_sum[9:0] - 10'd1;
        cmd_drop = ({1'b0, head.x} >= HLim) || ({1'b0, head.y} >= VLim) ||
                   (head.w == '0) || (head.h == '0);
        last_pix = (cur_x_q == x_last_q) && (cur_y_q == y_last_q);
        nxt_x    = cur_x_q + 10'd1;
        nxt_y    = cur_y_q;
        if (cur_x_q == x_last_q) begin
            nxt_x = x_first_q;
            nxt_y = cur_y_q + 10'd1;
        end
    end

    // Write registers always hold the pixel being presented this cycle, so
    // wr_en is high exactly while the state is CLEAR or DRAW.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            clr_addr_q <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            x_first_q  <= '0;
            x_last_q   <= '0;
            y_last_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    wr_en_q <= 1'b0;
                    if (start) begin
                        clr_addr_q <= '0;
                        wr_addr_q  <= '0;
                        wr_data_q  <= bg_color;
                        wr_en_q    <= 1'b1;
                        state_q    <= StClear;
                    end
                end
                StClear: begin
                    if (clr_addr_q == LastAddr) begin
                        wr_en_q <= 1'b0;
                        state_q <= StFetch;
                    end else begin
                        clr_addr_q <= clr_addr_q + FB_ADDR_W'(1);
                        wr_addr_q  <= clr_addr_q + FB_ADDR_W'(1);
                    end
                end
                StFetch: begin
                    if (fifo_empty) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (!cmd_drop) begin
                        cur_x_q   <= head.x;
                        cur_y_q   <= head.y;
                        x_first_q <= head.x;
                        x_last_q  <= x_last;
                        y_last_q  <= y_last;
                        wr_addr_q <= pix_addr(head.x, head.y);
                        wr_data_q <= head.color;
                        wr_en_q   <= 1'b1;
                        state_q   <= StDraw;
                    end
                end
                StDraw: begin
                    if (last_pix) begin
                        wr_en_q <= 1'b0;
                        state_q <= StFetch;
                    end else begin
                        cur_x_q   <= nxt_x;
                        cur_y_q   <= nxt_y;
                        wr_addr_q <= pix_addr(nxt_x, nxt_y);
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_en     = wr_en_q;

endmodule
